// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one backing-memory port between the icache (read-only)
// and dcache (read/write) miss paths. One block request is accepted at a time.
// For each request the arbiter issues one command, then streams BEATS data
// beats: write beats go out to memory, and read beats come back to the owner.
//
// Build option:
//   MEM_ARBITER_RR_EN  defined   -> round-robin between the caches on a tie
//                      undefined -> fixed priority, the dcache wins every tie
module mem_arbiter #(
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128,
    parameter int BEATS     = 4,
    parameter int TAG_BITS  = 5
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   ic_req_valid,
    output logic                   ic_req_ready,
    input  logic [ADDR_BITS-1:0]   ic_req_addr,
    output logic                   ic_resp_valid,
    output logic [DATA_BITS-1:0]   ic_resp_data,

    input  logic                   dc_req_valid,
    output logic                   dc_req_ready,
    input  logic                   dc_req_rw,
    input  logic [ADDR_BITS-1:0]   dc_req_addr,
    input  logic                   dc_wdata_valid,
    output logic                   dc_wdata_ready,
    input  logic [DATA_BITS-1:0]   dc_wdata,
    input  logic [DATA_BITS/8-1:0] dc_wmask,
    output logic                   dc_resp_valid,
    output logic [DATA_BITS-1:0]   dc_resp_data,

    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_req_rw,
    output logic [ADDR_BITS-1:0]   mem_req_addr,
    output logic [TAG_BITS-1:0]    mem_req_tag,
    output logic                   mem_wdata_valid,
    input  logic                   mem_wdata_ready,
    output logic [DATA_BITS-1:0]   mem_wdata,
    output logic [DATA_BITS/8-1:0] mem_wmask,
    input  logic                   mem_resp_valid,
    input  logic [TAG_BITS-1:0]    mem_resp_tag,
    input  logic [DATA_BITS-1:0]   mem_resp_data
);

    localparam int                 CNT_BITS = $clog2(BEATS) + 1;
    localparam logic [TAG_BITS-1:0] IC_TAG  = '0;
    localparam logic [TAG_BITS-1:0] DC_TAG  = TAG_BITS'(1);
    localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IC, OWN_DC}        owner_t;

    state_t                r_state;
    state_t                w_next_state;
    owner_t                r_owner;
    logic                  r_rw;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [CNT_BITS-1:0]   r_beat_cnt;
`ifdef MEM_ARBITER_RR_EN
    owner_t                r_last_owner;
`endif

    logic                  w_grant_ic;
    logic                  w_grant_dc;
    logic                  w_req_fire;
    logic                  w_wbeat_fire;
    logic                  w_resp_hit;
    logic                  w_last_beat;
    logic [TAG_BITS-1:0]   w_owner_tag;

    // Arbitration between the two caches; this only matters while the arbiter is IDLE.
    always_comb begin
`ifdef MEM_ARBITER_RR_EN
        w_grant_ic = ic_req_valid && (!dc_req_valid || (r_last_owner == OWN_DC));
`else
        w_grant_ic = ic_req_valid && !dc_req_valid;
`endif
        w_grant_dc = dc_req_valid && !w_grant_ic;
    end

    // Transfer events. Reset blocks every handshake, so a pending beat is abandoned.
    assign w_owner_tag  = (r_owner == OWN_DC) ? DC_TAG : IC_TAG;
    assign w_req_fire   = !reset && (r_state == S_IDLE) && (w_grant_ic || w_grant_dc);
    assign w_wbeat_fire = !reset && (r_state == S_WDATA) && dc_wdata_valid && mem_wdata_ready;
    assign w_resp_hit   = !reset && (r_state == S_RDATA) && mem_resp_valid
                          && (mem_resp_tag == w_owner_tag);
    assign w_last_beat  = (r_beat_cnt == LAST_BEAT);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments only, so every
        // register samples values from before the edge and the order of statements does not matter.
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: IDLE -> CMD -> (WDATA | RDATA) -> IDLE.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (w_req_fire) w_next_state = S_CMD;
            S_CMD:   if (mem_req_ready) w_next_state = r_rw ? S_WDATA : S_RDATA;
            S_WDATA: if (w_wbeat_fire && w_last_beat) w_next_state = S_IDLE;
            S_RDATA: if (w_resp_hit && w_last_beat) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Transfer context: the owner, direction and address are latched at grant, and the beat counter tracks progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner      <= OWN_NONE;
            r_rw         <= 1'b0;
            r_addr       <= '0;
            r_beat_cnt   <= '0;
`ifdef MEM_ARBITER_RR_EN
            r_last_owner <= OWN_IC;
`endif
        end else if (w_req_fire) begin
            // The icache never writes, so only a dcache grant can set rw.
            r_owner      <= w_grant_dc ? OWN_DC : OWN_IC;
            r_rw         <= w_grant_dc && dc_req_rw;
            r_addr       <= w_grant_dc ? dc_req_addr : ic_req_addr;
            r_beat_cnt   <= '0;
`ifdef MEM_ARBITER_RR_EN
            r_last_owner <= w_grant_dc ? OWN_DC : OWN_IC;
`endif
        end else if ((r_state != S_IDLE) && (w_next_state == S_IDLE)) begin
            r_owner    <= OWN_NONE;
            r_beat_cnt <= '0;
        end else if (w_wbeat_fire || w_resp_hit) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end

    // Output decode. Every output is held at 0 during reset and outside its own phase.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a value
        // unassigned and no latch is inferred.
        ic_req_ready    = 1'b0;
        dc_req_ready    = 1'b0;
        ic_resp_valid   = 1'b0;
        ic_resp_data    = '0;
        dc_resp_valid   = 1'b0;
        dc_resp_data    = '0;
        dc_wdata_ready  = 1'b0;
        mem_req_valid   = 1'b0;
        mem_req_rw      = 1'b0;
        mem_req_addr    = '0;
        mem_req_tag     = '0;
        mem_wdata_valid = 1'b0;
        mem_wdata       = '0;
        mem_wmask       = '0;
        if (!reset) begin
            unique case (r_state)
                S_IDLE: begin
                    ic_req_ready = w_grant_ic;
                    dc_req_ready = w_grant_dc;
                end
                S_CMD: begin
                    mem_req_valid = 1'b1;
                    mem_req_rw    = r_rw;
                    mem_req_addr  = r_addr;
                    mem_req_tag   = w_owner_tag;
                end
                S_WDATA: begin
                    mem_wdata_valid = dc_wdata_valid;
                    dc_wdata_ready  = mem_wdata_ready;
                    mem_wdata       = dc_wdata;
                    mem_wmask       = dc_wmask;
                end
                S_RDATA: begin
                    if (w_resp_hit && (r_owner == OWN_IC)) begin
                        ic_resp_valid = 1'b1;
                        ic_resp_data  = mem_resp_data;
                    end
                    if (w_resp_hit && (r_owner == OWN_DC)) begin
                        dc_resp_valid = 1'b1;
                        dc_resp_data  = mem_resp_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
